sort_n_fsm: RTL

- Parametrised iterative sorter for N unsigned W-bit values using odd-even transposition sort.
- One compare-exchange phase per clock on a single register bank; ascending or descending order per vector.
- Valid/ready handshakes on both sides, so it drops into streaming datapaths between producer and consumer stages.
- Successor to the fixed 4x8-bit sorter: generalised width and element count, runtime sort direction, backpressure, optional early exit.

---
 rtl/sort_n_fsm_if.sv | 25 ++
 rtl/sort_n_fsm.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sort_n_fsm_if.sv
// Handshake bundle for sort_n_fsm.
// The producer/consumer side uses the master modport. The sorter uses the slave modport.
interface sort_n_fsm_if #(
   parameter int W = 8,
   parameter int N = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_data;
   logic           desc;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] out_data;
   logic           busy;

   modport master (
      output in_valid, in_data, desc, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, desc, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/sort_n_fsm.sv
// Iterative odd-even transposition sorter for N unsigned W-bit lanes.
// Each clock in SORT performs one compare-exchange phase on a single register bank.
// Optional macro SORT_EARLY_EXIT_EN: the sort finishes early once two consecutive
// phases make no swap.
module sort_n_fsm #(
   parameter int W  = 8,
   parameter int N  = 8,
   parameter int CW = $clog2(N+1)
) (
   input  logic        clk,
   input  logic        rst_n,
   sort_n_fsm_if.slave bus
);

   localparam logic [1:0]    IDLE = 2'd0;
   localparam logic [1:0]    SORT = 2'd1;
   localparam logic [1:0]    DONE = 2'd2;
   localparam logic [CW-1:0] LAST = CW'(N-1);

   logic [1:0]     state_q, state_d;
   logic [W-1:0]   bank_q [N];
   logic [W-1:0]   bank_d [N];
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           desc_q, desc_d;
   logic [N*W-1:0] out_data_q, out_data_d;

   logic [W-1:0]   phase_bank [N];
   logic [N*W-1:0] phase_flat;
   logic           swap;
   logic           exit_now;

   // One compare-exchange phase: even counter pairs (0,1),(2,3)..; odd counter pairs (1,2),(3,4)..
   always_comb begin
      phase_bank = bank_q;
      swap       = 1'b0;
      for (int i = 0; i < N-1; i++) begin
         if (i[0] == cnt_q[0]) begin
            if (desc_q ? (bank_q[i] < bank_q[i+1]) : (bank_q[i] > bank_q[i+1])) begin
               phase_bank[i]   = bank_q[i+1];
               phase_bank[i+1] = bank_q[i];
               swap            = 1'b1;
            end
         end
      end
   end

   // Flatten the post-phase bank into the output lane packing
   always_comb begin
      phase_flat = '0;
      for (int k = 0; k < N; k++) begin
         phase_flat[k*W +: W] = phase_bank[k];
      end
   end

`ifdef SORT_EARLY_EXIT_EN
   logic noswap_q, noswap_d;

   // Two swap-free phases in a row (both parities clean) mean the bank is fully sorted
   assign exit_now = (cnt_q == LAST) | (~swap & noswap_q);

   // Track whether the previous phase was swap-free; cleared on every accept
   always_comb begin
      noswap_d = noswap_q;
      if (state_q == IDLE && bus.in_valid) begin
         noswap_d = 1'b0;
      end else if (state_q == SORT) begin
         noswap_d = ~swap;
      end
   end

   // Previous-phase swap flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) noswap_q <= 1'b0;
      else        noswap_q <= noswap_d;
   end
`else
   assign exit_now = (cnt_q == LAST);
`endif

   // Next-state logic: in_data is read only on an accept, so no other cycle can latch it
   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      cnt_d      = cnt_q;
      desc_d     = desc_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = SORT;
               for (int k = 0; k < N; k++) begin
                  bank_d[k] = bus.in_data[k*W +: W];
               end
               desc_d = bus.desc;
               cnt_d  = '0;
            end
         end
         SORT: begin
            bank_d = phase_bank;
            cnt_d  = cnt_q + 1'b1;
            if (exit_now) begin
               state_d    = DONE;
               out_data_d = phase_flat;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, bank and output registers; reset abandons any vector in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bank_q     <= '{default: '0};
         cnt_q      <= '0;
         desc_q     <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         cnt_q      <= cnt_d;
         desc_q     <= desc_d;
         out_data_q <= out_data_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;

endmodule
